// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the FSM state enum and the instruction field bit positions.
package fetch_pkg;

  localparam int INSTR_W = 16;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    KILL
  } state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus: instruction memory, branch redirect and decode handshake.
// master = fetch unit side, slave = environment (memory/execute/decode).
interface instr_fetch_unit_if
  import fetch_pkg::*;
#(
  parameter int PC_W = 16
);

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               br_taken;
  logic [PC_W-1:0]    br_target;
  logic               ir_valid;
  logic               ir_ready;
  logic [3:0]         opcode;
  logic [3:0]         rd;
  logic [7:0]         imm8;
  logic [PC_W-1:0]    ir_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    input  br_taken, br_target,
    output ir_valid, opcode, rd, imm8, ir_pc,
    input  ir_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    output br_taken, br_target,
    input  ir_valid, opcode, rd, imm8, ir_pc,
    output ir_ready
  );

endinterface

// File: rtl/instr_fetch_unit_pc.sv
// Program counter: redirect load has priority over increment.
// Increment wraps naturally at the top of the address space.
module fetch_pc #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_target,
  input  logic            incr,
  input  logic [PC_W-1:0] br_target,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_target)
      pc_d = br_target;
    else if (incr)
      pc_d = pc_q + PC_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pc_q <= RESET_PC;
    else
      pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch FSM with IR and field split.
// Bus outputs decode from registered state only.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_unit_if.master  fif
);

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [PC_W-1:0]    irpc_q, irpc_d;
  logic [PC_W-1:0]    kaddr_q, kaddr_d;
  logic [PC_W-1:0]    pc;
  logic               load_target;
  logic               incr;

  fetch_pc #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_target (load_target),
    .incr        (incr),
    .br_target   (fif.br_target),
    .pc          (pc)
  );

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    irpc_d      = irpc_q;
    kaddr_d     = kaddr_q;
    load_target = 1'b0;
    incr        = 1'b0;
    unique case (state_q)
      IDLE: begin
        load_target = fif.br_taken;
        state_d     = FETCH;
      end
      FETCH: begin
        if (fif.br_taken) begin
          load_target = 1'b1;
          kaddr_d     = pc;
          state_d     = fif.imem_ack ? FETCH : KILL;
        end else if (fif.imem_ack) begin
          ir_d    = fif.imem_rdata;
          irpc_d  = pc;
          incr    = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (fif.br_taken) begin
          load_target = 1'b1;
          state_d     = FETCH;
        end else if (fif.ir_ready) begin
          state_d = FETCH;
        end
      end
      KILL: begin
        // pending request keeps its address in kaddr_q
        load_target = fif.br_taken;
        if (fif.imem_ack)
          state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ir_q    <= '0;
      irpc_q  <= '0;
      kaddr_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      irpc_q  <= irpc_d;
      kaddr_q <= kaddr_d;
    end
  end

  assign fif.imem_req  = (state_q == FETCH) || (state_q == KILL);
  assign fif.imem_addr = (state_q == KILL) ? kaddr_q : pc;
  assign fif.ir_valid  = (state_q == HOLD);
  assign fif.opcode    = ir_q[OPC_MSB:OPC_LSB];
  assign fif.rd        = ir_q[RD_MSB:RD_LSB];
  assign fif.imm8      = ir_q[IMM_MSB:IMM_LSB];
  assign fif.ir_pc     = irpc_q;

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetches 16-bit instruction words from instruction memory and holds each one in an instruction register (IR). It splits the IR into opcode, register and 8-bit immediate fields; `imm8` drives the 8-to-16 sign-extension unit directly downstream. A single-entry valid/ready handshake to decode and a branch-redirect port complete the interface.

## Interface
- `PC_W`, 16, program counter and instruction-memory address width (word addressed)
- `RESET_PC`, 16'h0000, first fetch address after reset
- `clk`  in  1  single clock; all state changes on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `imem_req`  out  1  fetch request; high until acknowledged
- `imem_addr`  out  PC_W  fetch address; stable while `imem_req` is high
- `imem_ack`  in  1  memory acknowledge; `imem_rdata` is valid in the same cycle
- `imem_rdata`  in  16  instruction word
- `br_taken`  in  1  one-cycle redirect pulse from execute
- `br_target`  in  PC_W  redirect address, sampled when `br_taken` is high
- `ir_valid`  out  1  IR holds an instruction for decode
- `ir_ready`  in  1  decode accepts the IR
- `opcode`  out  4  IR[15:12]
- `rd`  out  4  IR[11:8]
- `imm8`  out  8  IR[7:0], consumed by the sign-extension unit
- `ir_pc`  out  PC_W  address from which the current IR was fetched

## Operation
- **IDLE** (reset state):
  - `imem_req`=0.
  - Moves unconditionally to FETCH on the first edge after `rst_n` rises.
- **FETCH**:
  - `imem_req`=1, `imem_addr`=pc.
  - On `imem_ack`: IR←`imem_rdata`, `ir_pc`←pc, pc←pc+1 (wraps 16'hFFFF→16'h0000), go to HOLD.
- **HOLD**:
  - `ir_valid`=1, `imem_req`=0.
  - On `ir_ready`: go to FETCH.
- **KILL**:
  - `imem_req`=1 and `imem_addr` keep the old address until `imem_ack`; memory handshakes are never abandoned.
  - On `imem_ack`: discard data, go to FETCH; pc already holds `br_target`.
- **Branch redirect** (`br_taken` has priority over every other event):
  - In FETCH without `imem_ack`: pc←`br_target`, go to KILL.
  - In FETCH with `imem_ack` in the same cycle: do not load the IR, pc←`br_target`, go to FETCH.
  - In HOLD: `ir_valid`→0, pc←`br_target`, go to FETCH. This holds whether or not `ir_ready` is high; a simultaneous `ir_ready` counts as a completed handshake.
  - In KILL: pc←new `br_target`; stay in KILL.
  - In IDLE: pc←`br_target`.
- **Field outputs**:
  - `opcode`, `rd`, `imm8` and `ir_pc` are pure slices and registers; no arithmetic is applied to them.
  - They are meaningful only while `ir_valid`=1 and hold their values while it is low.
- **Reset values**:
  - State IDLE, pc=`RESET_PC`, IR=16'h0000, `ir_pc`=16'h0000.
  - `imem_req`=0, `ir_valid`=0, `imem_addr`=`RESET_PC`.
- **Reset mid-operation**: asserting `rst_n` low in any state forces the reset values immediately. An outstanding memory request is dropped, and the memory is reset by the same `rst_n`.

## Timing
- `imem_req`, `imem_addr` and `ir_valid` are decoded from registered state and pc only, with no combinational path from any input.
- **Fetch latency**: ack in cycle N → `ir_valid`=1 in cycle N+1.
- **Issue rate**:
  - `ir_ready` in cycle M → `imem_req`=1 in cycle M+1.
  - Best case is one instruction every 2 cycles with single-cycle ack.
- **Redirect timing**:
  - `br_taken` in cycle N → `imem_addr`=`br_target` in cycle N+1, except from KILL, which waits for the pending ack.
  - No instruction fetched before the redirect ever reaches `ir_valid`=1.
- `ir_valid` never drops without a handshake, except on `br_taken` or reset.

## Structure
- The shared package `fetch_pkg` holds:
  - the state enum (IDLE, FETCH, HOLD, KILL)
  - the field bit positions `OPC_MSB`/`OPC_LSB`, `RD_MSB`/`RD_LSB`, `IMM_MSB`/`IMM_LSB`
  - `INSTR_W`=16
- One sub-module is natural: `fetch_pc`, the PC register with increment, wrap and redirect mux. Its controls are `load_target`, `incr` and `br_target`.
- The FSM and IR live in the top module.

## Test plan
- **Reset and first fetch**: hold `rst_n` low, then release → `imem_req`=0 in the first cycle and 1 at address 16'h0000 in the second. Ack with 16'h3A85 → `opcode`=3, `rd`=A, `imm8`=85, `ir_pc`=0000, `ir_valid`=1 the next cycle.
- **Backpressure**: hold `ir_ready`=0 for 5 cycles in HOLD → `ir_valid` stays 1, fields stay stable, `imem_req`=0. Raise `ir_ready` → `imem_req`=1 at 16'h0001 the next cycle.
- **Delayed ack and kill**: fetch at 16'h0004 with ack delayed 3 cycles; pulse `br_taken` with target 16'h0040 in wait cycle 1. Required response:
  - `imem_addr` stays 0004 until the ack;
  - the acked data is discarded and `ir_valid` stays 0;
  - the next request is at 0040.
- **Branch in HOLD with simultaneous ready**: `br_taken` (target 16'h0100) and `ir_ready` both high → `ir_valid`=0 next cycle, next fetch at 0100.
- **PC wrap**: set `br_target`=16'hFFFF and fetch it → next fetch address 16'h0000, and `ir_pc` of the first instruction is FFFF.
- **Async reset mid-HOLD**: pull `rst_n` low between clock edges → `ir_valid` and `imem_req` go to 0 and `imem_addr` to 16'h0000 without waiting for a clock edge.
